axil_write64_reg: RTL and testbench
===================================

AXIL_WRITE64_REG -- requirements
Module: axil_write64_reg

Interface
REQ-001 SHALL have parameter AXI_DATA_WIDTH, default 32, AXI data bus width.
REQ-002 SHALL have parameter AXI_ADDR_WIDTH, default 16, AXI address width.
REQ-003 SHALL have parameter RESET_VALUE, default 64'h0, register value after reset.
REQ-004 SHALL have one clock and asynchronous active-low reset, ports as follows:
- aclk  in  1  system clock, all logic on rising edge
- aresetn  in  1  asynchronous active-low reset
- s_axi_awaddr  in  AXI_ADDR_WIDTH  write address
- s_axi_awvalid / s_axi_awready  in / out  1  write address handshake
- s_axi_wdata  in  AXI_DATA_WIDTH  write data
- s_axi_wstrb  in  AXI_DATA_WIDTH/8  byte enables
- s_axi_wvalid / s_axi_wready  in / out  1  write data handshake
- s_axi_bresp  out  2  write response, always OKAY
- s_axi_bvalid / s_axi_bready  out / in  1  write response handshake
- s_axi_araddr  in  AXI_ADDR_WIDTH  read address
- s_axi_arvalid / s_axi_arready  in / out  1  read address handshake
- s_axi_rdata  out  AXI_DATA_WIDTH  read data
- s_axi_rresp  out  2  read response, always OKAY
- s_axi_rvalid / s_axi_rready  out / in  1  read data handshake
- regdata0  out  AXI_DATA_WIDTH  committed register bits [31:0]
- regdata1  out  AXI_DATA_WIDTH  committed register bits [63:32]
- update  out  1  one-cycle pulse when a new 64-bit value commits

Function
REQ-005 SHALL decode only awaddr[2]: 0 = low word, 1 = high word; other address bits ignored, both words 32 bits regardless of bus width.
REQ-006 SHALL accept AW and W independently, in either order or same cycle; awready drops the cycle after AW handshake, wready drops the cycle after W handshake.
REQ-007 SHALL implement write FSM IDLE -> COMMIT -> RESP -> IDLE; IDLE waits until both AW and W captured; COMMIT lasts one cycle; RESP holds bvalid=1 until bvalid&bready.
REQ-008 Low-word write SHALL update shadow register only (per wstrb byte); regdata0/1 unchanged.
REQ-009 High-word write SHALL, in COMMIT, load regdata1 from wdata (per wstrb, unstrobed bytes keep old value) and regdata0 from shadow, atomically, and pulse update for exactly that cycle.
REQ-010 Latency: AW and W both complete at edge N -> regdata updated and update=1 after edge N+1, bvalid=1 after edge N+2.
REQ-011 awready and wready SHALL re-assert the cycle after the B handshake; no new AW/W accepted while a response is pending.
REQ-012 bvalid SHALL stay high, unchanged, while bready=0 (backpressure of any length).
REQ-013 Shadow SHALL persist across commits; a high-word write with no preceding low-word write commits the current shadow contents.
REQ-014 bresp and rresp SHALL be 2'b00 at all times.

Reset
REQ-015 Asynchronous assertion of aresetn SHALL immediately set: awready=1, wready=1, bvalid=0, arready=1, rvalid=0, rdata=0, update=0, shadow=RESET_VALUE[31:0], regdata0=RESET_VALUE[31:0], regdata1=RESET_VALUE[63:32], FSM=IDLE.
REQ-016 Reset mid-transaction SHALL discard any captured AW/W with no commit and no response.

Configuration
REQ-017 With AXIL_WRITE64_READBACK_EN defined, read channel SHALL return regdata0 (araddr[2]=0) or regdata1 (araddr[2]=1): arready drops after AR handshake, rvalid asserted next cycle with data, held until rready, then arready re-asserts and rdata clears to 0.
REQ-018 Without AXIL_WRITE64_READBACK_EN, read channel SHALL use the same handshake timing but rdata SHALL always be 0.

Structure
REQ-019 Shared package SHALL hold the AXI response constant OKAY=2'b00, word-select bit index 2, and FSM state encoding.
REQ-020 Write-channel capture and the optional read responder are one module; no sub-module.

Verification
REQ-021 AW addr 0x0 data 0x11223344 wstrb 0xF, then AW addr 0x4 data 0xAABBCCDD -> after 2nd, regdata1=0xAABBCCDD, regdata0=0x11223344, update single pulse; after 1st only, regdata unchanged.
REQ-022 W before AW by 3 cycles, addr 0x4 -> commit after AW, one bvalid, bresp=0.
REQ-023 bready low 10 cycles -> bvalid held, awready/wready low, second AW not accepted until B handshake.
REQ-024 Addr 0x4, wstrb 0x3, data 0xFFFFFFFF over regdata1=0 -> regdata1=0x0000FFFF.
REQ-025 aresetn low while AW captured, W pending -> no update, no bvalid, outputs equal RESET_VALUE.
REQ-026 With READBACK_EN, read 0x4 after REQ-021 -> rdata=0xAABBCCDD; without it -> rdata=0, handshake completes.

Source files
------------

// File: rtl/axil_write64_reg_pkg.sv
// Shared definitions for the 64-bit AXI-Lite write register: response code,
// word-select address bit, write FSM encoding and a byte-strobe merge helper.
// Latency: n/a (package). Backpressure: n/a.
package axil_write64_reg_pkg;

    // AXI response code; this block never reports an error.
    localparam logic [1:0] RESP_OKAY = 2'b00;

    // Address bit that selects the low (0) or high (1) 32-bit word.
    localparam int WORD_SEL_BIT = 2;

    // Write path: wait for AW+W, commit for one cycle, then hold the response.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COMMIT = 2'd1,
        ST_RESP   = 2'd2
    } wr_state_t;

    // Byte-wise merge: strobed bytes take the new value, others keep the old.
    function automatic logic [31:0] strb_merge(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  strb
    );
        logic [31:0] merged;
        for (int i = 0; i < 4; i++) begin
            merged[i*8 +: 8] = strb[i] ? new_word[i*8 +: 8] : old_word[i*8 +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/axil_write64_reg_if.sv
// AXI-Lite slave bus bundle (AW, W, B, AR, R channels) for axil_write64_reg.
// Latency: n/a (wires only). Backpressure: standard AXI valid/ready per channel.
// Modports: slave (the register block), master (the bus driver / testbench).
interface axil_write64_reg_if #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 16
);
    logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr;
    logic                        s_axi_awvalid;
    logic                        s_axi_awready;
    logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata;
    logic [AXI_DATA_WIDTH/8-1:0] s_axi_wstrb;
    logic                        s_axi_wvalid;
    logic                        s_axi_wready;
    logic [1:0]                  s_axi_bresp;
    logic                        s_axi_bvalid;
    logic                        s_axi_bready;
    logic [AXI_ADDR_WIDTH-1:0]   s_axi_araddr;
    logic                        s_axi_arvalid;
    logic                        s_axi_arready;
    logic [AXI_DATA_WIDTH-1:0]   s_axi_rdata;
    logic [1:0]                  s_axi_rresp;
    logic                        s_axi_rvalid;
    logic                        s_axi_rready;

    modport slave (
        input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
               s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
        output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
               s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );

    modport master (
        output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
               s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
        input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
               s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );

endinterface

// File: rtl/axil_write64_reg.sv
// Atomically committed 64-bit register written as two 32-bit AXI-Lite words.
// Latency: AW+W done at edge N -> regdata/update after N+1, bvalid after N+2.
// Backpressure: one write in flight; AW/W/AR stall until the B/R handshake.
//
// Ports: aclk, aresetn (async active-low); s_axi (slave modport, full
// AXI-Lite); regdata0/regdata1 committed low/high words; update one-cycle
// pulse on each high-word commit.
// Option: define AXIL_WRITE64_READBACK_EN to return regdata0/1 on the read
// channel; otherwise reads complete with zero data.
module axil_write64_reg
    import axil_write64_reg_pkg::*;
#(
    parameter int          AXI_DATA_WIDTH = 32,
    parameter int          AXI_ADDR_WIDTH = 16,
    parameter logic [63:0] RESET_VALUE    = 64'h0
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    axil_write64_reg_if.slave         s_axi,
    output logic [AXI_DATA_WIDTH-1:0] regdata0,
    output logic [AXI_DATA_WIDTH-1:0] regdata1,
    output logic                      update
);

    wr_state_t                 state;
    logic                      awready;
    logic                      wready;
    logic                      bvalid;
    logic                      aw_sel;     // captured word select
    logic [31:0]               w_dat;      // captured write data (low 32 bits)
    logic [3:0]                w_strb;     // captured byte enables
    logic [31:0]               shadow;     // staged low word
    logic [31:0]               reg_lo;
    logic [31:0]               reg_hi;
    logic                      update_q;

    logic                      arready;
    logic                      rvalid;
    logic [AXI_DATA_WIDTH-1:0] rdata;

    // Only the word-select bit and the low 32 data bits matter; fold the rest
    // away so narrow use of wide buses is explicit.
    logic unused_bits;
    assign unused_bits = ^{s_axi.s_axi_awaddr, s_axi.s_axi_wdata,
                           s_axi.s_axi_wstrb, s_axi.s_axi_araddr};

    // Write path. A ready that has dropped doubles as the "captured" flag:
    // it only falls on a handshake and only rises after the B handshake.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= ST_IDLE;
            awready  <= 1'b1;
            wready   <= 1'b1;
            bvalid   <= 1'b0;
            aw_sel   <= 1'b0;
            w_dat    <= '0;
            w_strb   <= '0;
            shadow   <= RESET_VALUE[31:0];
            reg_lo   <= RESET_VALUE[31:0];
            reg_hi   <= RESET_VALUE[63:32];
            update_q <= 1'b0;
        end else begin
            update_q <= 1'b0;

            if (s_axi.s_axi_awvalid && awready) begin
                awready <= 1'b0;
                aw_sel  <= s_axi.s_axi_awaddr[WORD_SEL_BIT];
            end
            if (s_axi.s_axi_wvalid && wready) begin
                wready <= 1'b0;
                w_dat  <= s_axi.s_axi_wdata[31:0];
                w_strb <= s_axi.s_axi_wstrb[3:0];
            end

            case (state)
                ST_IDLE: begin
                    if (!awready && !wready) begin
                        // Registers load on entry so they are valid throughout
                        // the COMMIT cycle, together with the update pulse.
                        state <= ST_COMMIT;
                        if (aw_sel) begin
                            reg_hi   <= strb_merge(reg_hi, w_dat, w_strb);
                            reg_lo   <= shadow;
                            update_q <= 1'b1;
                        end else begin
                            shadow <= strb_merge(shadow, w_dat, w_strb);
                        end
                    end
                end
                ST_COMMIT: begin
                    state  <= ST_RESP;
                    bvalid <= 1'b1;
                end
                ST_RESP: begin
                    if (s_axi.s_axi_bready) begin
                        state   <= ST_IDLE;
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        wready  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Read path: single outstanding read, data captured at the AR handshake.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            arready <= 1'b1;
            rvalid  <= 1'b0;
            rdata   <= '0;
        end else if (s_axi.s_axi_arvalid && arready) begin
            arready <= 1'b0;
            rvalid  <= 1'b1;
`ifdef AXIL_WRITE64_READBACK_EN
            rdata   <= s_axi.s_axi_araddr[WORD_SEL_BIT] ? AXI_DATA_WIDTH'(reg_hi)
                                                        : AXI_DATA_WIDTH'(reg_lo);
`else
            rdata   <= '0;
`endif
        end else if (rvalid && s_axi.s_axi_rready) begin
            arready <= 1'b1;
            rvalid  <= 1'b0;
            rdata   <= '0;
        end
    end

    assign s_axi.s_axi_awready = awready;
    assign s_axi.s_axi_wready  = wready;
    assign s_axi.s_axi_bvalid  = bvalid;
    assign s_axi.s_axi_bresp   = RESP_OKAY;
    assign s_axi.s_axi_arready = arready;
    assign s_axi.s_axi_rvalid  = rvalid;
    assign s_axi.s_axi_rdata   = rdata;
    assign s_axi.s_axi_rresp   = RESP_OKAY;

    assign regdata0 = AXI_DATA_WIDTH'(reg_lo);
    assign regdata1 = AXI_DATA_WIDTH'(reg_hi);
    assign update   = update_q;

endmodule

// File: tb/tb_axil_write64_reg.sv
// Directed self-checking bench for axil_write64_reg.
// Latency: checks one-edge commit and two-edge response timing.
// Backpressure: exercises long bready stalls and AW/W ordering.
module tb_axil_write64_reg;

    logic        aclk;
    logic        aresetn;
    logic [31:0] regdata0;
    logic [31:0] regdata1;
    logic        update;

    int total;
    int bad;

    axil_write64_reg_if #(.AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(16)) bus ();

    axil_write64_reg #(
        .AXI_DATA_WIDTH(32),
        .AXI_ADDR_WIDTH(16),
        .RESET_VALUE   (64'h0)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .s_axi   (bus.slave),
        .regdata0(regdata0),
        .regdata1(regdata1),
        .update  (update)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Full write with bounded waits; bready pulsed once bvalid shows up.
    task automatic do_write(input logic [15:0] addr, input logic [31:0] data,
                            input logic [3:0] strb);
        bit aw_done, w_done, aw_hs, w_hs;
        int n;
        bus.s_axi_awaddr  = addr;
        bus.s_axi_awvalid = 1'b1;
        bus.s_axi_wdata   = data;
        bus.s_axi_wstrb   = strb;
        bus.s_axi_wvalid  = 1'b1;
        aw_done = 1'b0;
        w_done  = 1'b0;
        n = 0;
        while (!(aw_done && w_done) && n < 20) begin
            aw_hs = bus.s_axi_awvalid && bus.s_axi_awready;
            w_hs  = bus.s_axi_wvalid && bus.s_axi_wready;
            tick();
            if (aw_hs) begin aw_done = 1'b1; bus.s_axi_awvalid = 1'b0; end
            if (w_hs)  begin w_done  = 1'b1; bus.s_axi_wvalid  = 1'b0; end
            n++;
        end
        chk("wr_accept", {62'b0, aw_done, w_done}, 64'd3);
        n = 0;
        while (!bus.s_axi_bvalid && n < 20) begin
            tick();
            n++;
        end
        chk("wr_bvalid", bus.s_axi_bvalid, 1);
        bus.s_axi_bready = 1'b1;
        tick();
        bus.s_axi_bready = 1'b0;
        chk("wr_bdone", bus.s_axi_bvalid, 0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        aresetn = 1'b0;
        bus.s_axi_awaddr  = '0;
        bus.s_axi_awvalid = 1'b0;
        bus.s_axi_wdata   = '0;
        bus.s_axi_wstrb   = '0;
        bus.s_axi_wvalid  = 1'b0;
        bus.s_axi_bready  = 1'b0;
        bus.s_axi_araddr  = '0;
        bus.s_axi_arvalid = 1'b0;
        bus.s_axi_rready  = 1'b0;

        // Reset state
        #12;
        chk("rst_awready", bus.s_axi_awready, 1);
        chk("rst_wready",  bus.s_axi_wready, 1);
        chk("rst_bvalid",  bus.s_axi_bvalid, 0);
        chk("rst_arready", bus.s_axi_arready, 1);
        chk("rst_rvalid",  bus.s_axi_rvalid, 0);
        chk("rst_rdata",   bus.s_axi_rdata, 0);
        chk("rst_update",  update, 0);
        chk("rst_reg0",    regdata0, 0);
        chk("rst_reg1",    regdata1, 0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        tick();

        // Low-word write, AW and W in the same cycle: shadow only.
        bus.s_axi_awaddr  = 16'h0000;
        bus.s_axi_awvalid = 1'b1;
        bus.s_axi_wdata   = 32'h1122_3344;
        bus.s_axi_wstrb   = 4'hF;
        bus.s_axi_wvalid  = 1'b1;
        tick();                                   // edge N: both handshakes
        bus.s_axi_awvalid = 1'b0;
        bus.s_axi_wvalid  = 1'b0;
        chk("lo_awready_drop", bus.s_axi_awready, 0);
        chk("lo_wready_drop",  bus.s_axi_wready, 0);
        tick();                                   // N+1: commit (shadow)
        chk("lo_update",  update, 0);
        chk("lo_reg0",    regdata0, 32'h0);
        chk("lo_reg1",    regdata1, 32'h0);
        chk("lo_bvalid_early", bus.s_axi_bvalid, 0);
        tick();                                   // N+2: response
        chk("lo_bvalid",  bus.s_axi_bvalid, 1);
        chk("lo_bresp",   bus.s_axi_bresp, 0);
        bus.s_axi_bready = 1'b1;
        tick();
        bus.s_axi_bready = 1'b0;
        chk("lo_bdone",   bus.s_axi_bvalid, 0);
        chk("lo_awready_back", bus.s_axi_awready, 1);
        chk("lo_wready_back",  bus.s_axi_wready, 1);

        // High-word write: atomic commit of both words with one update pulse.
        bus.s_axi_awaddr  = 16'h0004;
        bus.s_axi_awvalid = 1'b1;
        bus.s_axi_wdata   = 32'hAABB_CCDD;
        bus.s_axi_wstrb   = 4'hF;
        bus.s_axi_wvalid  = 1'b1;
        tick();
        bus.s_axi_awvalid = 1'b0;
        bus.s_axi_wvalid  = 1'b0;
        chk("hi_update_early", update, 0);
        tick();
        chk("hi_update", update, 1);
        chk("hi_reg1",   regdata1, 32'hAABB_CCDD);
        chk("hi_reg0",   regdata0, 32'h1122_3344);
        tick();
        chk("hi_update_pulse", update, 0);
        chk("hi_bvalid", bus.s_axi_bvalid, 1);
        bus.s_axi_bready = 1'b1;
        tick();
        bus.s_axi_bready = 1'b0;
        chk("hi_bdone",  bus.s_axi_bvalid, 0);

        // Readback of both words.
        bus.s_axi_araddr  = 16'h0004;
        bus.s_axi_arvalid = 1'b1;
        tick();
        bus.s_axi_arvalid = 1'b0;
        chk("rd_arready_drop", bus.s_axi_arready, 0);
        chk("rd_rvalid", bus.s_axi_rvalid, 1);
        chk("rd_rresp",  bus.s_axi_rresp, 0);
`ifdef AXIL_WRITE64_READBACK_EN
        chk("rd_hi_data", bus.s_axi_rdata, 32'hAABB_CCDD);
`else
        chk("rd_hi_data", bus.s_axi_rdata, 32'h0);
`endif
        tick();
        chk("rd_rvalid_hold", bus.s_axi_rvalid, 1);
        bus.s_axi_rready = 1'b1;
        tick();
        bus.s_axi_rready = 1'b0;
        chk("rd_rdone",   bus.s_axi_rvalid, 0);
        chk("rd_arready_back", bus.s_axi_arready, 1);
        chk("rd_rdata_clr", bus.s_axi_rdata, 0);
        bus.s_axi_araddr  = 16'h0000;
        bus.s_axi_arvalid = 1'b1;
        tick();
        bus.s_axi_arvalid = 1'b0;
`ifdef AXIL_WRITE64_READBACK_EN
        chk("rd_lo_data", bus.s_axi_rdata, 32'h1122_3344);
`else
        chk("rd_lo_data", bus.s_axi_rdata, 32'h0);
`endif
        bus.s_axi_rready = 1'b1;
        tick();
        bus.s_axi_rready = 1'b0;
        chk("rd_lo_done", bus.s_axi_rvalid, 0);

        // W three cycles before AW; shadow persists from the first write.
        bus.s_axi_wdata  = 32'h5566_7788;
        bus.s_axi_wstrb  = 4'hF;
        bus.s_axi_wvalid = 1'b1;
        tick();
        bus.s_axi_wvalid = 1'b0;
        tick();
        tick();
        tick();
        chk("wfirst_wready",  bus.s_axi_wready, 0);
        chk("wfirst_awready", bus.s_axi_awready, 1);
        chk("wfirst_update",  update, 0);
        chk("wfirst_bvalid",  bus.s_axi_bvalid, 0);
        bus.s_axi_awaddr  = 16'h0004;
        bus.s_axi_awvalid = 1'b1;
        tick();
        bus.s_axi_awvalid = 1'b0;
        tick();
        chk("wfirst_commit", update, 1);
        chk("wfirst_reg1",   regdata1, 32'h5566_7788);
        chk("wfirst_reg0",   regdata0, 32'h1122_3344);
        tick();
        chk("wfirst_bvalid2", bus.s_axi_bvalid, 1);
        chk("wfirst_bresp",   bus.s_axi_bresp, 0);

        // Long B backpressure with a second AW waiting.
        bus.s_axi_awaddr  = 16'h0000;
        bus.s_axi_awvalid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_bvalid",  bus.s_axi_bvalid, 1);
            chk("bp_awready", bus.s_axi_awready, 0);
            chk("bp_wready",  bus.s_axi_wready, 0);
        end
        bus.s_axi_bready = 1'b1;
        tick();
        bus.s_axi_bready = 1'b0;
        chk("bp_bdone",   bus.s_axi_bvalid, 0);
        chk("bp_awready_back", bus.s_axi_awready, 1);
        tick();                                   // queued AW taken now
        bus.s_axi_awvalid = 1'b0;
        chk("bp_aw2_taken", bus.s_axi_awready, 0);
        // Its data carries no strobes, so the shadow stays as it was.
        bus.s_axi_wdata  = 32'hCAFE_F00D;
        bus.s_axi_wstrb  = 4'h0;
        bus.s_axi_wvalid = 1'b1;
        tick();
        bus.s_axi_wvalid = 1'b0;
        tick();
        chk("bp_lo_noupdate", update, 0);
        tick();
        chk("bp_bvalid2", bus.s_axi_bvalid, 1);
        bus.s_axi_bready = 1'b1;
        tick();
        bus.s_axi_bready = 1'b0;

        // Partial strobes on the high word and on the shadow.
        do_write(16'h0004, 32'h0000_0000, 4'hF);
        chk("strb_reg1_zero", regdata1, 32'h0);
        chk("strb_reg0_keep", regdata0, 32'h1122_3344);
        do_write(16'h0004, 32'hFFFF_FFFF, 4'h3);
        chk("strb_reg1_half", regdata1, 32'h0000_FFFF);
        do_write(16'h0000, 32'hA5A5_A5A5, 4'h4);
        chk("strb_lo_noreg0", regdata0, 32'h1122_3344);
        do_write(16'h0004, 32'h1234_5678, 4'h0);
        chk("strb_reg1_none", regdata1, 32'h0000_FFFF);
        chk("strb_reg0_shadow", regdata0, 32'h11A5_3344);

        // Reset while AW captured and W pending.
        bus.s_axi_awaddr  = 16'h0004;
        bus.s_axi_awvalid = 1'b1;
        tick();
        bus.s_axi_awvalid = 1'b0;
        chk("mid_aw_taken", bus.s_axi_awready, 0);
        #2;
        aresetn = 1'b0;
        #1;
        chk("mid_awready", bus.s_axi_awready, 1);
        chk("mid_wready",  bus.s_axi_wready, 1);
        chk("mid_bvalid",  bus.s_axi_bvalid, 0);
        chk("mid_update",  update, 0);
        chk("mid_reg0",    regdata0, 0);
        chk("mid_reg1",    regdata1, 0);
        tick();
        aresetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_update",  update, 0);
            chk("post_bvalid",  bus.s_axi_bvalid, 0);
            chk("post_awready", bus.s_axi_awready, 1);
            chk("post_wready",  bus.s_axi_wready, 1);
        end
        // Shadow came back to its reset value.
        do_write(16'h0004, 32'h0102_0304, 4'hF);
        chk("post_reg1", regdata1, 32'h0102_0304);
        chk("post_reg0", regdata0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
